// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU: grant, hold operands SETTLE cycles, capture, respond.
// Define ALU_ARB_ROUNDROBIN_EN for round-robin tie-breaking; otherwise requester 0 has fixed priority.
module alu_arbiter #(
    parameter int WIDTH  = 32,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req0_cmd,
    input  logic [2:0]       req1_cmd,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    input  logic             rsp0_ready,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [2:0]       rsp_flags,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_cmd,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carryout,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    output logic [1:0]       dbg_state_o
);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             grant_q, grant_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [2:0]       cmd_q, cmd_d, flags_q, flags_d;
    logic             win1;
`ifdef ALU_ARB_ROUNDROBIN_EN
    logic             last_q, last_d;
`endif

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // ready is combinational from valid, a requester holds valid and payload until it sees ready.
`ifdef ALU_ARB_ROUNDROBIN_EN
    assign win1 = req1_valid && (!req0_valid || !last_q);
`else
    assign win1 = req1_valid && !req0_valid;
`endif

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        cmd_d      = cmd_q;
        res_d      = res_q;
        flags_d    = flags_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
`ifdef ALU_ARB_ROUNDROBIN_EN
        last_d     = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                req0_ready = req0_valid && !win1;
                req1_ready = win1;
                if (req0_valid || req1_valid) begin
                    grant_d = win1;
                    a_d     = win1 ? req1_a   : req0_a;
                    b_d     = win1 ? req1_b   : req0_b;
                    cmd_d   = win1 ? req1_cmd : req0_cmd;
                    cnt_d   = CW'(SETTLE - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    res_d   = alu_result;
                    flags_d = {alu_carryout, alu_zero, alu_overflow};
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                rsp0_valid = !grant_q;
                rsp1_valid = grant_q;
                // Only the granted port's ready is looked at.
                if (grant_q ? rsp1_ready : rsp0_ready) begin
                    state_d = S_IDLE;
`ifdef ALU_ARB_ROUNDROBIN_EN
                    last_d  = grant_q;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            grant_q <= 1'b0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cmd_q   <= '0;
            res_q   <= '0;
            flags_q <= '0;
`ifdef ALU_ARB_ROUNDROBIN_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cmd_q   <= cmd_d;
            res_q   <= res_d;
            flags_q <= flags_d;
`ifdef ALU_ARB_ROUNDROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_cmd     = cmd_q;
    assign rsp_result  = res_q;
    assign rsp_flags   = flags_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized scoreboard bench for alu_arbiter: a behavioural ALU and arbitration model drive an expected-response queue.
module tb_alu_arbiter;
    localparam int W  = 32;
    localparam int ST = 2;
`ifdef ALU_ARB_ROUNDROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  cmd;
        logic [34:0] exp;
    } op_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]   req0_cmd, req1_cmd;
    logic         rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [W-1:0] rsp_result, alu_a, alu_b, alu_result;
    logic [2:0]   rsp_flags, alu_cmd;
    logic         alu_carryout, alu_zero, alu_overflow;
    logic [1:0]   dbg_state;

    logic         q4_valid, q4_ready, q4_ready1, q4_rsp_valid, q4_rsp_valid1, q4_rsp_ready;
    logic [W-1:0] q4_a, q4_b, q4_result, q4_alu_a, q4_alu_b, q4_alu_result;
    logic [2:0]   q4_cmd, q4_flags, q4_alu_cmd;
    logic         q4_c, q4_z, q4_v;
    logic [1:0]   dbg_state4;
    logic         zero1 = 1'b0;
    logic [W-1:0] zero_w = '0;
    logic [2:0]   zero_c = '0;

    // Behavioural ALU: returns {carryout, zero, overflow, result}.
    function automatic logic [34:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [2:0] cmd);
        logic [32:0] s;
        logic [31:0] r;
        logic c, v;
        c = 1'b0; v = 1'b0; r = a; s = '0;
        case (cmd)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
                        v = (a[31] == b[31]) && (r[31] != a[31]); end
            3'd1: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; c = s[32];
                        v = (a[31] != b[31]) && (r[31] != a[31]); end
            3'd2: r = a ^ b;
            3'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd4: r = (a != b) ? 32'd1 : 32'd0;
            default: r = a;
        endcase
        return {c, (r == 32'd0), v, r};
    endfunction

    assign {alu_carryout, alu_zero, alu_overflow, alu_result} = alu_f(alu_a, alu_b, alu_cmd);
    assign {q4_c, q4_z, q4_v, q4_alu_result} = alu_f(q4_alu_a, q4_alu_b, q4_alu_cmd);

    alu_arbiter #(.WIDTH(W), .SETTLE(ST)) u_dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_cmd(req0_cmd), .req1_cmd(req1_cmd),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd),
        .alu_result(alu_result), .alu_carryout(alu_carryout),
        .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .dbg_state_o(dbg_state)
    );

    alu_arbiter #(.WIDTH(W), .SETTLE(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .req0_valid(q4_valid), .req1_valid(zero1),
        .req0_ready(q4_ready), .req1_ready(q4_ready1),
        .req0_a(q4_a), .req0_b(q4_b), .req1_a(zero_w), .req1_b(zero_w),
        .req0_cmd(q4_cmd), .req1_cmd(zero_c),
        .rsp0_valid(q4_rsp_valid), .rsp1_valid(q4_rsp_valid1),
        .rsp0_ready(q4_rsp_ready), .rsp1_ready(zero1),
        .rsp_result(q4_result), .rsp_flags(q4_flags),
        .alu_a(q4_alu_a), .alu_b(q4_alu_b), .alu_cmd(q4_alu_cmd),
        .alu_result(q4_alu_result), .alu_carryout(q4_c),
        .alu_zero(q4_z), .alu_overflow(q4_v),
        .dbg_state_o(dbg_state4)
    );

    // Scoreboard and model state
    op_t         pend0[$], pend1[$];
    logic [35:0] exp_q[$];          // {requester, flags, result}
    int          gnt_exp_q[$];
    int          n_tests = 0, n_fail = 0, cyc = 0, acc_cyc = 0;
    bit          busy = 1'b0, last = 1'b1, rsp_seen = 1'b0, acc0 = 1'b0, acc1 = 1'b0;
    int          rdy_mode0 = 0, rdy_mode1 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic op_t mk(input logic [31:0] a, input logic [31:0] b, input logic [2:0] cmd, input logic [34:0] e);
        op_t o;
        o.a = a; o.b = b; o.cmd = cmd; o.exp = e;
        return o;
    endfunction

    function automatic op_t mk_rand();
        logic [31:0] a, b;
        logic [2:0]  c;
        a = $urandom();
        b = ($urandom_range(0, 3) == 0) ? a : $urandom();
        c = 3'($urandom_range(0, 7));
        return mk(a, b, c, alu_f(a, b, c));
    endfunction

    // Monitor: models arbitration and compares responses against exp_q.
    initial begin
        int          w, act;
        logic [35:0] head;
        logic        hs;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (!busy) begin
                    chk("rsp_while_idle", {rsp1_valid, rsp0_valid}, 2'b00);
                    if (req0_valid || req1_valid) begin
                        if (req0_valid && req1_valid) w = RR ? int'(!last) : 0;
                        else w = req1_valid ? 1 : 0;
                        chk("grant_winner", {req1_ready, req0_ready}, (w == 1) ? 2'b10 : 2'b01);
                        if (req0_ready || req1_ready) begin
                            act = req1_ready ? 1 : 0;
                            if (gnt_exp_q.size() > 0) chk("grant_order", act, gnt_exp_q.pop_front());
                            if (act == 1) begin exp_q.push_back({1'b1, pend1[0].exp}); acc1 = 1'b1; end
                            else          begin exp_q.push_back({1'b0, pend0[0].exp}); acc0 = 1'b1; end
                            busy = 1'b1; acc_cyc = cyc; rsp_seen = 1'b0;
                        end
                    end else begin
                        chk("ready_no_req", {req1_ready, req0_ready}, 2'b00);
                    end
                end else begin
                    chk("ready_while_busy", {req1_ready, req0_ready}, 2'b00);
                    if (rsp0_valid || rsp1_valid) begin
                        if (exp_q.size() == 0) begin
                            chk("rsp_unexpected", {rsp1_valid, rsp0_valid}, 2'b00);
                        end else begin
                            head = exp_q[0];
                            chk("rsp_valid_sel", {rsp1_valid, rsp0_valid}, head[35] ? 2'b10 : 2'b01);
                            chk("rsp_data", {rsp_flags, rsp_result}, head[34:0]);
                            if (!rsp_seen) begin
                                rsp_seen = 1'b1;
                                chk("settle_latency", cyc - acc_cyc, ST + 1);
                            end
                            hs = head[35] ? rsp1_ready : rsp0_ready;
                            if (hs) begin
                                void'(exp_q.pop_front());
                                busy = 1'b0; last = head[35]; rsp_seen = 1'b0;
                            end
                        end
                    end else if (cyc - acc_cyc > ST + 1) begin
                        chk("rsp_missing", 1, 0);
                    end
                end
            end
        end
    end

    // Driver: one call per clock; consumes accepted ops and presents the next head.
    task automatic step();
        @(posedge clk);
        #1;
        if (acc0) begin void'(pend0.pop_front()); acc0 = 1'b0; end
        if (acc1) begin void'(pend1.pop_front()); acc1 = 1'b0; end
        req0_valid = (pend0.size() > 0);
        req1_valid = (pend1.size() > 0);
        if (req0_valid) begin req0_a = pend0[0].a; req0_b = pend0[0].b; req0_cmd = pend0[0].cmd; end
        else begin req0_a = $urandom(); req0_b = $urandom(); req0_cmd = 3'($urandom_range(0, 7)); end
        if (req1_valid) begin req1_a = pend1[0].a; req1_b = pend1[0].b; req1_cmd = pend1[0].cmd; end
        else begin req1_a = $urandom(); req1_b = $urandom(); req1_cmd = 3'($urandom_range(0, 7)); end
        rsp0_ready = (rdy_mode0 == 0) ? 1'b1 : (rdy_mode0 == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        rsp1_ready = (rdy_mode1 == 0) ? 1'b1 : (rdy_mode1 == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((pend0.size() > 0 || pend1.size() > 0 || busy || exp_q.size() > 0) && n < budget) begin
            step();
            n++;
        end
        chk("drain_timeout", (n >= budget) ? 1 : 0, 0);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0; req0_cmd = '0; req1_cmd = '0;
        q4_valid = 0; q4_a = '0; q4_b = '0; q4_cmd = '0; q4_rsp_ready = 0;

        @(negedge clk);
        chk("rst_ctrl", {req1_ready, req0_ready, rsp1_valid, rsp0_valid, alu_cmd, rsp_flags, dbg_state}, '0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_result", rsp_result, 0);
        @(posedge clk); #2 reset = 1'b0;

        // Directed: ADD on port 0, SUB on port 1
        pend0.push_back(mk(32'd1, 32'd1, 3'd0, {3'b000, 32'd2}));
        drain(50);
        pend1.push_back(mk(32'd5, 32'd5, 3'd1, {3'b110, 32'd0}));
        drain(50);

        // Tie: three ops on each port presented together
        if (RR) gnt_exp_q = '{0, 1, 0, 1, 0, 1};
        else    gnt_exp_q = '{0, 0, 0, 1, 1, 1};
        for (int i = 0; i < 3; i++) begin
            pend0.push_back(mk_rand());
            pend1.push_back(mk_rand());
        end
        drain(200);
        chk("grant_seq_done", gnt_exp_q.size(), 0);

        // Stall: response 0 held off while port 1 waits
        rdy_mode0 = 2;
        pend0.push_back(mk_rand());
        pend1.push_back(mk_rand());
        repeat (ST + 12) step();
        chk("req1_still_pending", pend1.size(), 1);
        chk("rsp0_still_held", {rsp1_valid, rsp0_valid}, 2'b01);
        rdy_mode0 = 0;
        drain(100);

        // Reset while in WAIT: op discarded, outputs cleared asynchronously
        pend0.push_back(mk(32'h1234_5678, 32'h1111_1111, 3'd0, 35'd0));
        n = 0;
        while (!busy && n < 10) begin step(); n++; end
        chk("mid_accept_seen", busy, 1);
        #2 reset = 1'b1;
        pend0.delete(); pend1.delete();
        req0_valid = 0; req1_valid = 0;
        #1;
        chk("mid_rst_ctrl", {req1_ready, req0_ready, rsp1_valid, rsp0_valid, alu_cmd, rsp_flags}, '0);
        chk("mid_rst_alu_ab", {alu_a, alu_b}, 0);
        chk("mid_rst_result", rsp_result, 0);
        exp_q.delete(); busy = 1'b0; last = 1'b1; rsp_seen = 1'b0; acc0 = 1'b0; acc1 = 1'b0;
        repeat (3) step();
        chk("mid_rst_no_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
        #2 reset = 1'b0;
        pend0.push_back(mk(32'hF0F0_F0F0, 32'hFFFF_FFFF, 3'd2, {3'b000, 32'h0F0F_0F0F}));
        drain(50);

        // Random traffic with random response back-pressure
        rdy_mode0 = 1; rdy_mode1 = 1;
        for (int i = 0; i < 25; i++) begin
            pend0.push_back(mk_rand());
            pend1.push_back(mk_rand());
        end
        drain(3000);
        rdy_mode0 = 0; rdy_mode1 = 0;

        // SETTLE=4 instance: SLT -1 < 1
        @(posedge clk); #1;
        q4_valid = 1; q4_a = 32'hFFFF_FFFF; q4_b = 32'd1; q4_cmd = 3'd3;
        @(negedge clk);
        chk("s4_accept", {q4_ready1, q4_ready}, 2'b01);
        @(posedge clk); #1;
        q4_valid = 0;
        chk("s4_state_wait", dbg_state4, 2'd1);
        n = 0;
        while (n < 12) begin
            @(posedge clk); #1;
            n++;
            if (q4_rsp_valid) break;
        end
        chk("s4_capture_edges", n, 4);
        chk("s4_rsp_sel", {q4_rsp_valid1, q4_rsp_valid}, 2'b01);
        chk("s4_result", {q4_flags, q4_result}, {3'b000, 32'd1});
        q4_rsp_ready = 1;
        @(posedge clk); #1;
        q4_rsp_ready = 0;
        chk("s4_rsp_done", q4_rsp_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational 32-bit `ALU` (commands ADD=0, SUB=1, XOR=2, SLT=3, CNE=4) between two requesters. Grants one request at a time, registers and holds its operands on the ALU inputs for a fixed settle period, captures result and flags, then returns them to the granted requester over a valid/ready response channel. Sits between the register-file/control side and the `ALU` instance; the ALU itself is unchanged.

## Interface
- `WIDTH`, 32, operand/result width
- `SETTLE`, 2, cycles operands are held on the ALU before capture (legal ≥1)

- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `req0_valid`, `req1_valid`  in  1  request present
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  WIDTH  operands
- `req0_cmd`, `req1_cmd`  in  3  ALU command
- `rsp0_valid`, `rsp1_valid`  out  1  response present
- `rsp0_ready`, `rsp1_ready`  in  1  response consumed
- `rsp_result`  out  WIDTH  captured result (shared by both responders)
- `rsp_flags`  out  3  {carryout, zero, overflow} captured
- `alu_a`, `alu_b`  out  WIDTH  to ALU operandA/operandB
- `alu_cmd`  out  3  to ALU command
- `alu_result`  in  WIDTH; `alu_carryout`, `alu_zero`, `alu_overflow`  in  1  from ALU

## Operation
- States: IDLE, WAIT, RESP. Reset → IDLE.
- IDLE: if any `reqN_valid`, select winner (see Configuration); `reqN_ready` = IDLE && `reqN_valid` && winner==N (combinational, at most one high). On handshake: latch a/b/cmd into `alu_a/alu_b/alu_cmd`, record grant, load counter = SETTLE−1, → WAIT.
- WAIT: decrement counter each cycle; when counter==0, capture `alu_result` and flags into `rsp_result/rsp_flags`, → RESP.
- RESP: `rspN_valid` high for granted N only; held with result stable until `rspN_ready`; on handshake → IDLE and update last-grant pointer. `rsp_ready` of the non-granted port ignored.
- Requests arriving in WAIT/RESP are not accepted; requester holds valid and operands until ready.
- Commands 5–7 forwarded to ALU unchanged; no checking.
- `alu_a/alu_b/alu_cmd` hold last issued values in IDLE.

## Timing
- Reset values: all ready/valid 0, `alu_a`, `alu_b`, `rsp_result` = 0, `alu_cmd` = 0, `rsp_flags` = 0, last-grant pointer = 1.
- Accept at edge T; ALU inputs change after T; capture at edge T+SETTLE; `rspN_valid` high from T+SETTLE.
- Minimum issue interval: SETTLE+2 cycles (response handshake cycle plus one IDLE cycle).
- Response held indefinitely while `rspN_ready` low; the other requester stalls.
- Reset mid-operation: immediate return to IDLE, in-flight op discarded, no response issued, pointer = 1.
- Both valid in the same IDLE cycle: exactly one accepted; the other retries next IDLE cycle.

## Configuration
- `ALU_ARB_ROUNDROBIN_EN` defined: when both request, the requester not granted last wins; pointer updates on each response handshake.
- Undefined: fixed priority, requester 0 always wins a tie; pointer unused.

## Test plan
- req0 ADD a=1,b=1 alone, SETTLE=2 → `req0_ready` same cycle, `rsp0_valid` 2 edges later, result=2, flags={0,0,0}.
- req1 SUB a=5,b=5 → result=0, zero=1, carryout=1, only `rsp1_valid` asserts.
- Both valid from reset, three back-to-back ops each, rsp ready always high → with macro: grants 0,1,0,1,0,1; without: 0,0,0 then 1,1,1.
- Hold `rsp0_ready` low 10 cycles with req1 valid → `rsp_result` stable, `req1_ready` stays 0; req1 accepted first IDLE cycle after rsp0 handshake.
- Assert `reset` during WAIT → all outputs 0 asynchronously, no response; next req0 XOR a=0xF0F0F0F0,b=0xFFFFFFFF → result 0x0F0F0F0F.
- SETTLE=4, SLT a=0xFFFFFFFF(−1), b=1 → capture exactly 4 edges after accept, result=1.
